// File: rtl/sha1_padder.sv
// SHA-1 message padder: packs a byte stream into 512-bit blocks, appending the 0x80 marker and 64-bit bit length.
// Optional SHA1_PADDER_ABORT_EN adds a synchronous abort input that returns the block to its reset state.
module sha1_padder (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  input  logic         in_keep,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_block,
  output logic         out_first,
  output logic         out_last
`ifdef SHA1_PADDER_ABORT_EN
  ,
  input  logic         abort
`endif
);

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_PAD  = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_PAD2 = 2'd3;

  logic [1:0]  state;
  logic [7:0]  buf_q [64];
  logic [6:0]  idx;
  logic [60:0] byte_cnt;
  logic        first_flag;
  logic        pend2;
  logic        marker_pend;
  logic        soft_clr;
  logic [63:0] bit_len;

`ifdef SHA1_PADDER_ABORT_EN
  assign soft_clr = abort;
`else
  assign soft_clr = 1'b0;
`endif

  assign bit_len   = {byte_cnt, 3'b000};
  assign in_ready  = (state == S_FILL);
  assign out_valid = (state == S_EMIT);

  always_comb begin
    out_block = '0;
    for (int unsigned i = 0; i < 64; i++)
      out_block[8*(63-i) +: 8] = buf_q[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_FILL;
      idx         <= '0;
      byte_cnt    <= '0;
      first_flag  <= 1'b1;
      pend2       <= 1'b0;
      marker_pend <= 1'b0;
      out_first   <= 1'b0;
      out_last    <= 1'b0;
      for (int unsigned i = 0; i < 64; i++) buf_q[i] <= '0;
    end else if (soft_clr) begin
      state       <= S_FILL;
      idx         <= '0;
      byte_cnt    <= '0;
      first_flag  <= 1'b1;
      pend2       <= 1'b0;
      marker_pend <= 1'b0;
      out_first   <= 1'b0;
      out_last    <= 1'b0;
      for (int unsigned i = 0; i < 64; i++) buf_q[i] <= '0;
    end else begin
      case (state)
        S_FILL: begin
          if (in_valid) begin
            if (in_keep) begin
              buf_q[idx[5:0]] <= in_data;
              byte_cnt        <= byte_cnt + 61'd1;
            end
            if (in_last) begin
              state <= S_PAD;
              idx   <= idx + {6'd0, in_keep};
            end else if (in_keep && idx == 7'd63) begin
              state     <= S_EMIT;
              out_first <= first_flag;
              out_last  <= 1'b0;
              pend2     <= 1'b0;
              idx       <= '0;
            end else if (in_keep) begin
              idx <= idx + 7'd1;
            end
          end
        end
        S_PAD: begin
          // idx == 64 matches no byte here, so a full data block passes through untouched
          for (int unsigned i = 0; i < 64; i++) begin
            if (7'(i) == idx)
              buf_q[i] <= 8'h80;
            else if (7'(i) > idx && (i < 56 || idx >= 7'd56))
              buf_q[i] <= 8'h00;
            else if (i >= 56 && idx <= 7'd55)
              buf_q[i] <= bit_len[8*(63-i) +: 8];
          end
          state       <= S_EMIT;
          out_first   <= first_flag;
          out_last    <= (idx <= 7'd55);
          pend2       <= (idx >= 7'd56);
          marker_pend <= (idx == 7'd64);
        end
        S_PAD2: begin
          for (int unsigned i = 0; i < 64; i++) begin
            if (i == 0)
              buf_q[i] <= marker_pend ? 8'h80 : 8'h00;
            else if (i < 56)
              buf_q[i] <= 8'h00;
            else
              buf_q[i] <= bit_len[8*(63-i) +: 8];
          end
          state     <= S_EMIT;
          out_first <= 1'b0;
          out_last  <= 1'b1;
          pend2     <= 1'b0;
        end
        default: begin
          if (out_ready) begin
            first_flag <= 1'b0;
            state      <= pend2 ? S_PAD2 : S_FILL;
            if (out_last) begin
              idx         <= '0;
              byte_cnt    <= '0;
              first_flag  <= 1'b1;
              marker_pend <= 1'b0;
              for (int unsigned i = 0; i < 64; i++) buf_q[i] <= '0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_padder.sv
// Self-checking bench for sha1_padder: a queue-based padding model predicts every emitted block.
// Define SHA1_PADDER_ABORT_EN to also exercise the abort input.
module tb_sha1_padder;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, in_last, in_keep;
  logic [7:0]   in_data;
  logic         out_valid, out_ready, out_first, out_last;
  logic [511:0] out_block;
`ifdef SHA1_PADDER_ABORT_EN
  logic         abort = 1'b0;
`endif

  sha1_padder dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_keep(in_keep),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .out_first(out_first), .out_last(out_last)
`ifdef SHA1_PADDER_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [511:0] exp_blk[$];
  logic         exp_first[$];
  logic         exp_last[$];
  logic [7:0]   msg[$];

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Padding model: message + 0x80 + zeros to 56 mod 64 + 64-bit big-endian bit length.
  task automatic model_push();
    logic [7:0]   p[$];
    logic [63:0]  len;
    logic [511:0] blk;
    int           nb;
    p   = msg;
    len = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int j = 7; j >= 0; j--) p.push_back(len[8*j +: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      blk = '0;
      for (int k = 0; k < 64; k++) blk = {blk[503:0], p[b*64 + k]};
      exp_blk.push_back(blk);
      exp_first.push_back(b == 0);
      exp_last.push_back(b == nb - 1);
    end
  endtask

  task automatic put(input logic [7:0] d, input logic l, input logic k);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_last = l; in_keep = k;
    while (!in_ready && t < 200) begin @(posedge clk); #2; t++; end
    if (t >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL put_timeout in_ready stuck low");
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic send_msg();
    model_push();
    if (msg.size() == 0) put(8'h00, 1'b1, 1'b0);
    else for (int j = 0; j < msg.size(); j++) put(msg[j], j == msg.size() - 1, 1'b1);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_blk.size() != 0 && t < 500) begin @(posedge clk); #2; t++; end
    if (t >= 500) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_blk.size());
    end
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_out_valid"}, 512'(out_valid), 512'(0));
    chk({nm, "_in_ready"},  512'(in_ready),  512'(1));
    chk({nm, "_out_block"}, out_block,       512'(0));
    chk({nm, "_out_first"}, 512'(out_first), 512'(0));
    chk({nm, "_out_last"},  512'(out_last),  512'(0));
  endtask

  // Compare process: every handshake against the model, plus hold stability while stalled.
  logic         prev_hold = 1'b0;
  logic [513:0] prev_out;
  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (out_valid) begin
        chk("in_ready_in_emit", 512'(in_ready), 512'(0));
        if (prev_hold) chk("hold_stable", 512'({out_first, out_last, out_block}), 512'(prev_out));
        if (out_ready) begin
          if (exp_blk.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_block got=%h required=none", out_block);
          end else begin
            chk("block", out_block, exp_blk.pop_front());
            chk("first", 512'(out_first), 512'(exp_first.pop_front()));
            chk("last",  512'(out_last),  512'(exp_last.pop_front()));
          end
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_out  = {out_first, out_last, out_block};
    end
  end

  task automatic send_abc();
    msg = {8'h61, 8'h62, 8'h63};
    send_msg();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_keep = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_idle("reset");
    reset = 1'b0;
    @(posedge clk); #2;
    chk("in_ready_after_reset", 512'(in_ready), 512'(1));

    // "abc": single block, pinned literally, latency 2 cycles
    send_abc();
    chk("pin_abc", exp_blk[exp_blk.size()-1], {32'h61626380, 416'h0, 64'h18});
    chk("abc_latency_1", 512'(out_valid), 512'(0));
    @(posedge clk); #2;
    chk("abc_latency_2", 512'(out_valid), 512'(1));
    wait_drain();

    // empty message
    msg = {};
    send_msg();
    chk("pin_empty", exp_blk[0], {8'h80, 440'h0, 64'h0});
    wait_drain();

    // 56 bytes: marker fits, length spills to a second block
    msg = {};
    for (int i = 0; i < 56; i++) msg.push_back(8'(i));
    send_msg();
    chk("pin_56_b2", exp_blk[1], {448'h0, 64'h1C0});
    wait_drain();

    // 55 bytes: tightest single-block case
    msg = {};
    for (int i = 0; i < 55; i++) msg.push_back(8'(8'hA0 + i));
    send_msg();
    chk("pin_55_count", 512'(exp_blk.size()), 512'(1));
    wait_drain();

    // 64 bytes with downstream stalled 5 cycles; stray beats offered meanwhile must be ignored
    out_ready = 1'b0;
    msg = {};
    for (int i = 0; i < 64; i++) msg.push_back(8'(255 - i));
    send_msg();
    chk("pin_64_b2", exp_blk[1], {8'h80, 440'h0, 64'h200});
    begin
      int t = 0;
      while (!out_valid && t < 20) begin @(posedge clk); #2; t++; end
      chk("stall_out_valid", 512'(out_valid), 512'(1));
    end
    in_valid = 1'b1; in_data = 8'hEE; in_last = 1'b1; in_keep = 1'b1;
    repeat (5) begin
      @(posedge clk); #2;
      chk("stall_in_ready", 512'(in_ready), 512'(0));
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    // 63 bytes (p=63) and 120 bytes (full block then p=56)
    msg = {};
    for (int i = 0; i < 63; i++) msg.push_back(8'(3 * i));
    send_msg();
    wait_drain();
    msg = {};
    for (int i = 0; i < 120; i++) msg.push_back(8'(7 * i + 1));
    send_msg();
    wait_drain();

    // reset mid-message discards the partial data
    for (int i = 0; i < 30; i++) put(8'(i + 1), 1'b0, 1'b1);
    #1 reset = 1'b1;
    #1 check_idle("async_reset");
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #2;
    send_abc();
    wait_drain();

`ifdef SHA1_PADDER_ABORT_EN
    for (int i = 0; i < 30; i++) put(8'(i + 9), 1'b0, 1'b1);
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    check_idle("abort");
    send_abc();
    wait_drain();
`endif

    repeat (4) @(posedge clk);
    chk("no_pending", 512'(exp_blk.size()), 512'(0));
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
